// File: rtl/axi_write_slave.sv
// AXI-style single-outstanding write responder: sinks one AW burst into a word memory and returns one B.
// Optional macro AXI_WS_BACKPRESSURE_EN inserts a one-cycle WREADY gap after every accepted W beat.
module axi_write_slave #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [ADDR_W-1:0]            AWADDR,
  input  logic [7:0]                   AWLEN,
  input  logic [2:0]                   AWSIZE,
  input  logic [1:0]                   AWBUSRT,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [DATA_W-1:0]            WDATA,
  input  logic                         WLAST,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [$clog2(MEM_DEPTH)-1:0] RD_ADDR,
  output logic [DATA_W-1:0]            RD_DATA
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          len;
  logic                fixed;
  logic [8:0]          beat_cnt;
  logic                err;
  logic                drop;
  logic [DATA_W-1:0]   mem [MEM_DEPTH];

  logic [ADDR_W-3:0]   word_idx;
  logic                in_range;
  logic                w_hs;
  logic                last_beat;
  logic                mem_we;
  logic                beat_err;
  logic                aw_bad;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    word_idx  = addr[ADDR_W-1:2];
    in_range  = 32'(word_idx) < 32'(MEM_DEPTH);
    w_hs      = (state == DATA) && WVALID && WREADY;
    last_beat = (beat_cnt == {1'b0, len});
    // A misplaced or missing WLAST flags the response but does not stop data from landing;
    // only a bad command or an out-of-range word suppresses writes.
    mem_we    = w_hs && !drop && in_range;
    beat_err  = !in_range || (WLAST != last_beat);
    aw_bad    = (AWSIZE != 3'b010) || AWBUSRT[1];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BRESP    <= 2'b00;
      addr     <= '0;
      len      <= '0;
      fixed    <= 1'b0;
      beat_cnt <= '0;
      err      <= 1'b0;
      drop     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (AWVALID && AWREADY) begin
            addr     <= AWADDR;
            len      <= AWLEN;
            fixed    <= (AWBUSRT == 2'b00);
            beat_cnt <= '0;
            err      <= aw_bad;
            drop     <= aw_bad;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b1;
            state    <= DATA;
          end else begin
            AWREADY  <= 1'b1;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (!fixed) addr <= addr + ADDR_W'(4);
            beat_cnt <= beat_cnt + 9'd1;
            err      <= err | beat_err;
            drop     <= drop | !in_range;
            if (last_beat) begin
              WREADY <= 1'b0;
              BVALID <= 1'b1;
              BRESP  <= (err | beat_err) ? 2'b10 : 2'b00;
              state  <= RESP;
            end else begin
`ifdef AXI_WS_BACKPRESSURE_EN
              WREADY <= 1'b0;
`else
              WREADY <= 1'b1;
`endif
            end
          end else begin
            WREADY <= 1'b1;
          end
        end
        RESP: begin
          if (BVALID && BREADY) begin
            BVALID  <= 1'b0;
            BRESP   <= 2'b00;
            AWREADY <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the memory array has no reset; its contents are undefined until written.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[word_idx[IDX_W-1:0]] <= WDATA;
  end

  assign RD_DATA = mem[RD_ADDR];

endmodule

// File: tb/tb_axi_write_slave.sv
// Directed self-checking bench for axi_write_slave: bursts, error responses, B backpressure and mid-burst reset.
module tb_axi_write_slave;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBUSRT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  RD_ADDR;
  logic [31:0] RD_DATA;

  int vectors     = 0;
  int miscompares = 0;

  axi_write_slave #(.ADDR_W(16), .DATA_W(32), .MEM_DEPTH(256)) dut (
    .CLK(CLK), .RESET(RESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBUSRT(AWBUSRT),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits at falling edges until the given ready is high; a timeout counts as a miscompare.
  task automatic wait_ready(input string tag, input bit aw);
    int n = 0;
    while (((aw ? AWREADY : WREADY) !== 1'b1) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic read_mem(input string tag, input logic [7:0] idx, input logic [31:0] exp);
    RD_ADDR = idx;
    #1;
    check(tag, RD_DATA, exp);
  endtask

  task automatic send_aw(input logic [15:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
    AWADDR = a; AWLEN = len; AWSIZE = sz; AWBUSRT = bt; AWVALID = 1'b1;
    wait_ready("awready", 1'b1);
    @(negedge CLK);
    AWVALID = 1'b0;
    check("aw_hs_awready", {31'd0, AWREADY}, 32'd0);
    check("aw_hs_wready", {31'd0, WREADY}, 32'd1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic last);
    WDATA = d; WLAST = last; WVALID = 1'b1;
    wait_ready("wready", 1'b0);
    @(negedge CLK);
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  // Full burst: data = base + beat, WLAST on beat last_at, BREADY held low for hold cycles.
  task automatic write_burst(input string tag, input logic [15:0] a, input logic [7:0] len,
                             input logic [2:0] sz, input logic [1:0] bt, input logic [31:0] base,
                             input int last_at, input logic [1:0] exp_resp, input int hold);
    send_aw(a, len, sz, bt);
    for (int i = 0; i <= int'(len); i++) send_w(base + 32'(i), i == last_at);
    check({tag, "_bvalid"}, {31'd0, BVALID}, 32'd1);
    check({tag, "_bresp"}, {30'd0, BRESP}, {30'd0, exp_resp});
    check({tag, "_wready_off"}, {31'd0, WREADY}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check({tag, "_bvalid_hold"}, {31'd0, BVALID}, 32'd1);
      check({tag, "_bresp_hold"}, {30'd0, BRESP}, {30'd0, exp_resp});
    end
    BREADY = 1'b1;
    @(negedge CLK);
    BREADY = 1'b0;
    check({tag, "_bvalid_clr"}, {31'd0, BVALID}, 32'd0);
    check({tag, "_awready_back"}, {31'd0, AWREADY}, 32'd1);
  endtask

  initial begin
    RESET = 1'b0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBUSRT = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; RD_ADDR = '0;

    // Reset state and AWREADY rising on the first edge after release.
    repeat (2) @(negedge CLK);
    check("rst_awready", {31'd0, AWREADY}, 32'd0);
    check("rst_wready", {31'd0, WREADY}, 32'd0);
    check("rst_bvalid", {31'd0, BVALID}, 32'd0);
    check("rst_bresp", {30'd0, BRESP}, 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    check("rel_awready", {31'd0, AWREADY}, 32'd1);

    // Known background words for later "unchanged" checks.
    write_burst("pre0", 16'h0000, 8'd0, 3'b010, 2'b01, 32'hA5A5_0000, 0, 2'b00, 0);
    write_burst("pre9", 16'h0024, 8'd0, 3'b010, 2'b01, 32'h9999_0000, 0, 2'b00, 0);
    write_burst("pre16", 16'h0040, 8'd1, 3'b010, 2'b01, 32'h1100_0000, 1, 2'b00, 0);

    // INCR 4 beats to words 4..7.
    write_burst("incr", 16'h0010, 8'd3, 3'b010, 2'b01, 32'd1, 3, 2'b00, 0);
    for (int i = 0; i < 4; i++) read_mem("incr_mem", 8'(4 + i), 32'(1 + i));

    // FIXED 3 beats stay on word 8; word 9 untouched.
    write_burst("fixed", 16'h0020, 8'd2, 3'b010, 2'b00, 32'hA, 2, 2'b00, 0);
    read_mem("fixed_mem8", 8'd8, 32'hC);
    read_mem("fixed_mem9", 8'd9, 32'h9999_0000);

    // Illegal AWSIZE: beats accepted, nothing written, SLVERR.
    write_burst("badsize", 16'h0040, 8'd1, 3'b001, 2'b01, 32'h77, 1, 2'b10, 0);
    read_mem("badsize_mem16", 8'd16, 32'h1100_0000);
    read_mem("badsize_mem17", 8'd17, 32'h1100_0001);

    // Unsupported burst type.
    write_burst("badburst", 16'h0140, 8'd0, 3'b010, 2'b10, 32'h600, 0, 2'b10, 0);

    // Last in-range word then word 256, which must not alias onto word 0.
    write_burst("edge", 16'h03FC, 8'd1, 3'b010, 2'b01, 32'hFF00, 1, 2'b10, 0);
    read_mem("edge_mem255", 8'd255, 32'hFF00);
    read_mem("edge_mem0", 8'd0, 32'hA5A5_0000);

    // Early WLAST: all 4 beats land, SLVERR held while BREADY stays low.
    write_burst("early_last", 16'h0100, 8'd3, 3'b010, 2'b01, 32'h500, 1, 2'b10, 5);
    for (int i = 0; i < 4; i++) read_mem("early_last_mem", 8'(64 + i), 32'h500 + 32'(i));

    // Missing WLAST on the final beat.
    write_burst("no_last", 16'h0180, 8'd0, 3'b010, 2'b01, 32'h700, 5, 2'b10, 0);
    read_mem("no_last_mem", 8'd96, 32'h700);

    // Reset during beat 2 of a 4-beat burst; memory written so far is retained.
    send_aw(16'h0080, 8'd3, 3'b010, 2'b01);
    send_w(32'h800, 1'b0);
    send_w(32'h801, 1'b0);
    WDATA = 32'h802; WVALID = 1'b1;
    #2 RESET = 1'b0;
    @(negedge CLK);
    check("midrst_awready", {31'd0, AWREADY}, 32'd0);
    check("midrst_wready", {31'd0, WREADY}, 32'd0);
    check("midrst_bvalid", {31'd0, BVALID}, 32'd0);
    check("midrst_bresp", {30'd0, BRESP}, 32'd0);
    WVALID = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    check("midrst_awready_back", {31'd0, AWREADY}, 32'd1);
    read_mem("midrst_mem32", 8'd32, 32'h800);
    read_mem("midrst_mem33", 8'd33, 32'h801);
    write_burst("post_rst", 16'h0090, 8'd0, 3'b010, 2'b01, 32'h900, 0, 2'b00, 0);
    read_mem("post_rst_mem", 8'd36, 32'h900);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
